rom_arbiter: RTL and testbench

- Shares one synchronous single-port ROM between two requesters. The ROM has 1-cycle read latency, with ReadEnable, Address and Data ports.
- Each requester asks for a burst: a start address plus a length. The arbiter grants round-robin, streams consecutive ROM reads with address wrap-around, and returns tagged data with Valid/Last strobes.
- Sits between client logic (e.g. text/pattern generators) and the ROM instance.

---
 rtl/rom_arbiter.sv | 128 ++++++++++++
 tb/tb_rom_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// Round-robin arbiter that shares one synchronous single-port ROM between two burst requesters.
// Streams consecutive reads with wrap-around and returns tagged data with Valid/Last strobes.
module rom_arbiter #(
    parameter int ADDRESS_WIDTH = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int MEMORY_DEPTH  = 16
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Req0Request_i,
    input  logic [ADDRESS_WIDTH-1:0] Req0Address_i,
    input  logic [ADDRESS_WIDTH-1:0] Req0Length_i,
    output logic                     Req0Grant_o,
    input  logic                     Req1Request_i,
    input  logic [ADDRESS_WIDTH-1:0] Req1Address_i,
    input  logic [ADDRESS_WIDTH-1:0] Req1Length_i,
    output logic                     Req1Grant_o,
    output logic [DATA_WIDTH-1:0]    Data_o,
    output logic                     Valid0_o,
    output logic                     Valid1_o,
    output logic                     Last_o,
    output logic                     Busy_o,
    output logic                     RomReadEnable_o,
    output logic [ADDRESS_WIDTH-1:0] RomAddress_o,
    input  logic [DATA_WIDTH-1:0]    RomData_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(MEMORY_DEPTH - 1);
    localparam logic [ADDRESS_WIDTH:0]   DEPTH_EXT = (ADDRESS_WIDTH + 1)'(MEMORY_DEPTH);

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [ADDRESS_WIDTH-1:0] count_q, count_d;
    logic                     owner_q, owner_d;
    logic                     ptr_q, ptr_d;
    logic                     first_q, first_d;
    logic                     valid0_q, valid1_q, last_q;
    logic [DATA_WIDTH-1:0]    data_q;

    logic                     winner;
    logic [ADDRESS_WIDTH-1:0] start_addr;
    logic [ADDRESS_WIDTH-1:0] start_len;

    // Only one requester active: it wins. Both active: the round-robin pointer decides.
    assign winner     = (Req0Request_i && Req1Request_i) ? ptr_q : Req1Request_i;
    assign start_addr = winner ? Req1Address_i : Req0Address_i;
    assign start_len  = winner ? Req1Length_i  : Req0Length_i;

    always_comb begin
        // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latches).
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        first_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Req0Request_i || Req1Request_i) begin
                    owner_d = winner;
                    addr_d  = ({1'b0, start_addr} >= DEPTH_EXT) ? '0 : start_addr;
                    count_d = start_len;
                    first_d = 1'b1;
                    state_d = BURST;
                end
            end
            BURST: begin
                addr_d  = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
                count_d = count_q - 1'b1;
                if (count_q == '0) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                ptr_d   = ~owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            count_q  <= '0;
            owner_q  <= 1'b0;
            ptr_q    <= 1'b0;
            first_q  <= 1'b0;
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
            last_q   <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            first_q  <= first_d;
            valid0_q <= (state_q == BURST) && !owner_q;
            valid1_q <= (state_q == BURST) && owner_q;
            last_q   <= (state_q == BURST) && (count_q == '0);
            if (valid0_q || valid1_q) begin
                data_q <= RomData_i;
            end
        end
    end

    // ROM data arrives the cycle after the read; pass it through then, hold it otherwise.
    assign Data_o          = (valid0_q || valid1_q) ? RomData_i : data_q;
    assign Valid0_o        = valid0_q;
    assign Valid1_o        = valid1_q;
    assign Last_o          = last_q;
    assign Busy_o          = (state_q != IDLE);
    assign RomReadEnable_o = (state_q == BURST);
    assign RomAddress_o    = (state_q == BURST) ? addr_q : '0;
    assign Req0Grant_o     = (state_q == BURST) && first_q && !owner_q;
    assign Req1Grant_o     = (state_q == BURST) && first_q && owner_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: a transaction-level burst model checks a depth-16 instance every cycle,
// directed literal checks pin the model and a depth-12 instance covers out-of-range start addresses.
module tb_rom_arbiter;

    localparam int DEPTH = 16;

    typedef struct packed {
        logic       g0;
        logic       g1;
        logic       re;
        logic [3:0] addr;
        logic [7:0] data;
        logic       v0;
        logic       v1;
        logic       last;
        logic       busy;
    } obs_t;

    logic       clk;
    logic       rst_n;
    logic       req0, req1;
    logic [3:0] a0, a1, l0, l1;

    logic       g0, g1, v0, v1, lst, bsy, re;
    logic [7:0] dat, rd;
    logic [3:0] ra;

    logic       g0_b, g1_b, v0_b, v1_b, lst_b, bsy_b, re_b;
    logic [7:0] dat_b, rd_b;
    logic [3:0] ra_b;

    logic [7:0] mem16 [16];
    logic [7:0] mem12 [12];

    int   checks   = 0;
    int   failures = 0;
    logic chk_en   = 1'b0;

    obs_t exp_q[$];
    obs_t cur = '0;
    obs_t act;

    rom_arbiter #(.ADDRESS_WIDTH(4), .DATA_WIDTH(8), .MEMORY_DEPTH(16)) dut16 (
        .Clock(clk), .Reset(rst_n),
        .Req0Request_i(req0), .Req0Address_i(a0), .Req0Length_i(l0), .Req0Grant_o(g0),
        .Req1Request_i(req1), .Req1Address_i(a1), .Req1Length_i(l1), .Req1Grant_o(g1),
        .Data_o(dat), .Valid0_o(v0), .Valid1_o(v1), .Last_o(lst), .Busy_o(bsy),
        .RomReadEnable_o(re), .RomAddress_o(ra), .RomData_i(rd)
    );

    rom_arbiter #(.ADDRESS_WIDTH(4), .DATA_WIDTH(8), .MEMORY_DEPTH(12)) dut12 (
        .Clock(clk), .Reset(rst_n),
        .Req0Request_i(req0), .Req0Address_i(a0), .Req0Length_i(l0), .Req0Grant_o(g0_b),
        .Req1Request_i(req1), .Req1Address_i(a1), .Req1Length_i(l1), .Req1Grant_o(g1_b),
        .Data_o(dat_b), .Valid0_o(v0_b), .Valid1_o(v1_b), .Last_o(lst_b), .Busy_o(bsy_b),
        .RomReadEnable_o(re_b), .RomAddress_o(ra_b), .RomData_i(rd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROMs with one cycle of read latency
    always @(posedge clk) begin
        if (re) rd <= mem16[ra];
        if (re_b && int'(ra_b) < 12) rd_b <= mem12[ra_b];
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, actual, required, $time);
        end
    endtask

    // Burst model: on an idle-cycle edge with a request, the whole burst is expanded into
    // per-cycle expected observations; afterwards the outputs idle with the last word held.
    initial begin : model
        int   ptr;
        int   win;
        int   a;
        int   len;
        logic [7:0] held;
        obs_t rec;
        ptr = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_q.delete();
                cur = '0;
                ptr = 0;
            end else begin
                if (!cur.busy && (req0 || req1)) begin
                    win  = (req0 && req1) ? ptr : (req1 ? 1 : 0);
                    a    = (win == 1) ? int'(a1) : int'(a0);
                    len  = (win == 1) ? int'(l1) : int'(l0);
                    if (a >= DEPTH) a = 0;
                    held = cur.data;
                    for (int k = 0; k <= len + 1; k++) begin
                        rec      = '0;
                        rec.busy = 1'b1;
                        if (k <= len) begin
                            rec.re   = 1'b1;
                            rec.addr = 4'((a + k) % DEPTH);
                        end
                        if (k == 0) begin
                            rec.g0 = (win == 0);
                            rec.g1 = (win == 1);
                        end else begin
                            held     = 8'(8'hA0 + ((a + k - 1) % DEPTH));
                            rec.v0   = (win == 0);
                            rec.v1   = (win == 1);
                            rec.last = (k == len + 1);
                        end
                        rec.data = held;
                        exp_q.push_back(rec);
                    end
                    ptr = 1 - win;
                end
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                end else begin
                    held     = cur.data;
                    cur      = '0;
                    cur.data = held;
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (chk_en) begin
                act = {g0, g1, re, ra, dat, v0, v1, lst, bsy};
                check("cycle_vs_model", 32'(act), 32'(cur));
                check("valid_exclusive", 32'(v0 & v1), 32'd0);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_out16"}, 32'({g0, g1, re, ra, dat, v0, v1, lst, bsy}), 32'd0);
        check({tag, "_out12"}, 32'({g0_b, g1_b, re_b, ra_b, dat_b, v0_b, v1_b, lst_b, bsy_b}), 32'd0);
    endtask

    // Called just after a falling edge: asserts reset mid-cycle, checks outputs, releases mid-cycle.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        #1 check_all_zero("reset_async");
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin : stim
        for (int i = 0; i < 16; i++) mem16[i] = 8'(8'hA0 + i);
        for (int i = 0; i < 12; i++) mem12[i] = 8'(8'hA0 + i);
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; a1 = '0; l0 = '0; l1 = '0;

        repeat (2) @(negedge clk);
        check_all_zero("reset_state");
        #2 rst_n = 1'b1;
        chk_en = 1'b1;

        // Basic burst: requester 0, addr 3, len 2
        @(negedge clk);
        req0 = 1'b1; a0 = 4'd3; l0 = 4'd2;
        @(negedge clk);
        check("b1_grant0", 32'(g0), 32'd1);
        check("b1_addr0", 32'(ra), 32'd3);
        req0 = 1'b0;
        @(negedge clk);
        check("b1_addr1", 32'(ra), 32'd4);
        check("b1_data0", 32'({v0, dat}), 32'h1A3);
        @(negedge clk);
        check("b1_addr2", 32'(ra), 32'd5);
        check("b1_data1", 32'({v0, dat}), 32'h1A4);
        @(negedge clk);
        check("b1_last", 32'({v0, lst, re, bsy, dat}), 32'h0DA5);
        @(negedge clk);
        check("b1_idle", 32'({bsy, v0, lst, dat}), 32'h0A5);

        // Wrap: requester 1, addr 14, len 3
        req1 = 1'b1; a1 = 4'd14; l1 = 4'd3;
        @(negedge clk);
        check("wrap_grant1", 32'({g0, g1, ra}), 32'h1E);
        req1 = 1'b0;
        @(negedge clk);
        check("wrap_w0", 32'({v0, v1, ra, dat}), 32'h1FAE);
        @(negedge clk);
        check("wrap_w1", 32'({v0, v1, ra, dat}), 32'h10AF);
        @(negedge clk);
        check("wrap_w2", 32'({v0, v1, ra, dat}), 32'h11A0);
        @(negedge clk);
        check("wrap_w3", 32'({v0, v1, lst, dat}), 32'h3A1);
        @(negedge clk);

        // Contention from reset, both len 0 and held
        do_reset();
        req0 = 1'b1; a0 = 4'd0; l0 = 4'd0;
        req1 = 1'b1; a1 = 4'd1; l1 = 4'd0;
        @(negedge clk);
        check("cont_first_req0", 32'({g0, g1, ra}), 32'h20);
        @(negedge clk);
        check("cont_data_req0", 32'({v0, v1, lst, dat}), 32'h5A0);
        @(negedge clk);
        check("cont_gap_idle", 32'({bsy, g0, g1}), 32'd0);
        @(negedge clk);
        check("cont_second_req1", 32'({g0, g1, ra}), 32'h11);
        @(negedge clk);
        check("cont_data_req1", 32'({v0, v1, lst, dat}), 32'h3A1);
        @(negedge clk);
        @(negedge clk);
        check("cont_third_req0", 32'({g0, g1, ra}), 32'h20);
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(negedge clk);

        // Request arriving during a len-7 burst is not granted until the burst ends
        req0 = 1'b1; a0 = 4'd0; l0 = 4'd7;
        @(negedge clk);
        check("mid_grant0", 32'(g0), 32'd1);
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        req1 = 1'b1; a1 = 4'd5; l1 = 4'd0;
        for (int c = 4; c <= 10; c++) begin
            @(negedge clk);
            check("mid_no_grant1", 32'(g1), 32'd0);
        end
        check("mid_idle_gap", 32'(bsy), 32'd0);
        @(negedge clk);
        check("mid_grant1", 32'({g1, ra}), 32'h15);
        req1 = 1'b0; a1 = 4'd9; l1 = 4'd4;
        @(negedge clk);
        check("mid_data1", 32'({v1, lst, dat}), 32'h3A5);
        repeat (2) @(negedge clk);

        // Reset asserted during the third read of a len-5 burst
        req0 = 1'b1; a0 = 4'd2; l0 = 4'd5;
        @(negedge clk);
        req0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_third_read", 32'({re, ra}), 32'h14);
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("rst_after_quiet", 32'({v0, v1, lst, bsy, v0_b, v1_b, lst_b, bsy_b}), 32'd0);
        end

        // Out-of-range start on the depth-12 instance: addr 13 -> 0
        req0 = 1'b1; a0 = 4'd13; l0 = 4'd1;
        @(negedge clk);
        check("oor_grant_addr", 32'({g0_b, ra_b}), 32'h10);
        req0 = 1'b0;
        @(negedge clk);
        check("oor_w0", 32'({v0_b, ra_b, dat_b}), 32'h11A0);
        @(negedge clk);
        check("oor_w1", 32'({v0_b, lst_b, dat_b}), 32'h3A1);
        @(negedge clk);
        check("oor_idle", 32'(bsy_b), 32'd0);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
